// File: rtl/fu_sequencer.sv
// Command sequencer for the 4-bit function unit: register file, load/operate issue, writeback.
// Optional zero flag is built only when FU_SEQ_ZFLAG_EN is defined.
module fu_sequencer #(
  parameter int unsigned FU_LAT = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_ld,
  input  logic [3:0] cmd_op,
  input  logic [1:0] cmd_ra,
  input  logic [1:0] cmd_rb,
  input  logic [1:0] cmd_rd,
  input  logic [3:0] cmd_imm,
  output logic [3:0] fu_a,
  output logic [3:0] fu_b,
  output logic [3:0] fu_sel,
  input  logic [3:0] fu_f_out,
  output logic       res_valid,
  output logic [3:0] res_data,
  output logic [1:0] res_rd,
  output logic       busy,
  output logic       z_flag
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] EXEC = 1'b1;
  localparam logic [2:0] LAT  = 3'(FU_LAT);

  logic [0:0] state;
  logic [2:0] cnt;
  logic [3:0] regs [4];
  logic [1:0] rd_q;

  logic       accept;
  logic       op_done;
  logic       wb_en;
  logic [3:0] wb_data;
  logic [1:0] wb_rd;

  assign cmd_ready = (state == IDLE);
  assign accept    = cmd_valid && cmd_ready;
  assign op_done   = (state == EXEC) && (cnt == 3'd0);

  // Load and operate writebacks never coincide: loads only land in IDLE
  assign wb_en   = (accept && cmd_ld) || op_done;
  assign wb_data = op_done ? fu_f_out : cmd_imm;
  assign wb_rd   = op_done ? rd_q : cmd_rd;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 3'd0;
      rd_q      <= 2'd0;
      fu_a      <= 4'd0;
      fu_b      <= 4'd0;
      fu_sel    <= 4'd0;
      res_valid <= 1'b0;
      res_data  <= 4'd0;
      res_rd    <= 2'd0;
      busy      <= 1'b0;
      for (int i = 0; i < 4; i++) regs[i] <= 4'd0;
    end else begin
      res_valid <= 1'b0;
      if (wb_en) begin
        regs[wb_rd] <= wb_data;
        res_valid   <= 1'b1;
        res_data    <= wb_data;
        res_rd      <= wb_rd;
      end
      if (state == IDLE) begin
        if (accept && !cmd_ld) begin
          fu_a   <= regs[cmd_ra];
          fu_b   <= regs[cmd_rb];
          fu_sel <= cmd_op;
          rd_q   <= cmd_rd;
          cnt    <= LAT;
          state  <= EXEC;
          busy   <= 1'b1;
        end
      end else if (cnt != 3'd0) begin
        cnt <= cnt - 3'd1;
      end else begin
        state <= IDLE;
        busy  <= 1'b0;
      end
    end
  end

`ifdef FU_SEQ_ZFLAG_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      z_flag <= 1'b0;
    end else if (wb_en) begin
      z_flag <= (wb_data == 4'h0);
    end
  end
`else
  assign z_flag = 1'b0;
`endif

endmodule
